// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer owning the HI/LO register pair.
// Shift-add multiplier and restoring divider on operand magnitudes, signs fixed up in a final cycle.
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div_zero
);

    localparam int unsigned CNT_W  = int'($clog2(WIDTH)) + 1;
    localparam int unsigned ACC_W  = WIDTH + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, div_zero_q;
    logic               is_div_q, neg_q, rneg_q, dz_q;
    logic [ACC_W-1:0]   acc_q;      // product upper half / partial remainder
    logic [WIDTH-1:0]   low_q;      // multiplier / quotient
    logic [WIDTH-1:0]   opnd_q;     // multiplicand / divisor
    logic [WIDTH-1:0]   raw_a_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [ACC_W-1:0]   mul_sum, rem_sh, trial;
    logic [WIDTH-1:0]   quot_sh;
    logic [ACC_W-1:0]   acc_d;
    logic [WIDTH-1:0]   low_d;
    logic [PROD_W-1:0]  prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Operand magnitudes, one iteration step of either algorithm, and the final sign fix-up
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? WIDTH'(-a) : a;
        b_mag     = b_neg ? WIDTH'(-b) : b;

        mul_sum   = acc_q + (low_q[0] ? {1'b0, opnd_q} : ACC_W'(0));
        rem_sh    = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
        quot_sh   = {low_q[WIDTH-2:0], 1'b0};
        trial     = rem_sh - {1'b0, opnd_q};

        acc_d = acc_q;
        low_d = low_q;
        if (is_div_q) begin
            if (!trial[ACC_W-1]) begin
                acc_d = trial;
                low_d = quot_sh | WIDTH'(1);
            end else begin
                acc_d = rem_sh;
                low_d = quot_sh;
            end
        end else begin
            acc_d = {1'b0, mul_sum[ACC_W-1:1]};
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end

        prod     = {acc_q[WIDTH-1:0], low_q};
        prod_fix = neg_q  ? PROD_W'(-prod) : prod;
        quot_fix = neg_q  ? WIDTH'(-low_q) : low_q;
        rem_fix  = rneg_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end

    // Sequencer FSM, datapath registers and HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            low_q      <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_q <= op[1];
                                neg_q    <= a_neg ^ b_neg;
                                rneg_q   <= a_neg;
                                dz_q     <= op[1] && (b == '0);
                                acc_q    <= '0;
                                low_q    <= op[1] ? a_mag : b_mag;
                                opnd_q   <= op[1] ? b_mag : a_mag;
                                raw_a_q  <= a;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= S_CALC;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    low_q <= low_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[PROD_W-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_q <= raw_a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    if (is_div_q) begin
                        div_zero_q <= dz_q;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign stall    = busy_q & (hilo_rd | start);

endmodule
